// File: rtl/decode_queue.sv
// Instruction queue between fetch and ID: each MIPS32 word is decoded once on
// enqueue and the head entry is presented to ID with its control bundle.
module decode_queue #(
  parameter int DEPTH      = 4,
  parameter int PC_W       = 32,
  parameter int HAS_MULDIV = 1,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic [PC_W-1:0]          out_pc,
  output logic [16:0]              out_ctrl,
  output logic                     out_invalid,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         invalid_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]      ONE_COUNT  = (AW+1)'(1);
  localparam logic [AW-1:0]    ONE_PTR    = AW'(1);
  localparam logic [CNT_W-1:0] ONE_CNT    = CNT_W'(1);

  // Control bundle bit positions, MSB first.
  localparam int B_REGWRITE   = 16;
  localparam int B_REGDST_HI  = 15;
  localparam int B_REGDST_LO  = 14;
  localparam int B_ALUSRC     = 13;
  localparam int B_BRANCH     = 12;
  localparam int B_MEMWRITE   = 11;
  localparam int B_MEMTOREG   = 10;
  localparam int B_JUMP       = 9;
  localparam int B_HILO_WRITE = 8;
  localparam int B_JBRAL      = 7;
  localparam int B_JR         = 6;
  localparam int B_CP0_WRITE  = 5;
  localparam int B_MEMREAD    = 4;
  localparam int B_HILOTOREG  = 3;
  localparam int B_CP0TOREG   = 2;
  localparam int B_MFHI       = 1;
  localparam int B_MFLO       = 0;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f;
  localparam logic [5:0] OP_COP0 = 6'h10;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2b;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_JALR = 6'h09;
  localparam logic [5:0] F_SYSCALL = 6'h0c, F_BREAK = 6'h0d;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b;
  localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2a, F_SLTU = 6'h2b, F_ERET = 6'h18;

  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;
  localparam logic [4:0] RS_MFC0 = 5'h00, RS_MTC0 = 5'h04, RS_ERET = 5'h10;

  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [31:0]     inst_mem [DEPTH];
  logic [PC_W-1:0] pc_mem   [DEPTH];
  logic [16:0]     ctrl_mem [DEPTH];
  logic            inv_mem  [DEPTH];

  logic        push, pop;
  logic [16:0] dec_ctrl;
  logic        dec_invalid;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt;

  // Both sides are valid/ready: a transfer happens only in a cycle where valid
  // and ready are both high; a full queue never accepts, even while popping.
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign op    = in_inst[31:26];
  assign rs    = in_inst[25:21];
  assign rt    = in_inst[20:16];
  assign funct = in_inst[5:0];

  always_comb begin
    dec_ctrl    = '0;
    dec_invalid = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU,
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: begin
            dec_ctrl[B_REGWRITE]  = 1'b1;
            dec_ctrl[B_REGDST_LO] = 1'b1;
          end
          F_MFHI, F_MFLO: begin
            if (HAS_MULDIV != 0) begin
              dec_ctrl[B_REGWRITE]  = 1'b1;
              dec_ctrl[B_REGDST_LO] = 1'b1;
              dec_ctrl[B_HILOTOREG] = 1'b1;
              dec_ctrl[B_MFHI]      = (funct == F_MFHI);
              dec_ctrl[B_MFLO]      = (funct == F_MFLO);
            end else begin
              dec_invalid = 1'b1;
            end
          end
          F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO: begin
            if (HAS_MULDIV != 0) dec_ctrl[B_HILO_WRITE] = 1'b1;
            else dec_invalid = 1'b1;
          end
          F_JR: dec_ctrl[B_JR] = 1'b1;
          F_JALR: begin
            dec_ctrl[B_REGWRITE]  = 1'b1;
            dec_ctrl[B_REGDST_LO] = 1'b1;
            dec_ctrl[B_JBRAL]     = 1'b1;
            dec_ctrl[B_JR]        = 1'b1;
          end
          F_SYSCALL, F_BREAK: begin
          end
          default: dec_invalid = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ: dec_ctrl[B_BRANCH] = 1'b1;
          RT_BLTZAL, RT_BGEZAL: begin
            dec_ctrl[B_REGWRITE]  = 1'b1;
            dec_ctrl[B_REGDST_HI] = 1'b1;
            dec_ctrl[B_BRANCH]    = 1'b1;
            dec_ctrl[B_JBRAL]     = 1'b1;
          end
          default: dec_invalid = 1'b1;
        endcase
      end
      OP_J: dec_ctrl[B_JUMP] = 1'b1;
      OP_JAL: begin
        dec_ctrl[B_REGWRITE]  = 1'b1;
        dec_ctrl[B_REGDST_HI] = 1'b1;
        dec_ctrl[B_JUMP]      = 1'b1;
        dec_ctrl[B_JBRAL]     = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: dec_ctrl[B_BRANCH] = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        dec_ctrl[B_REGWRITE] = 1'b1;
        dec_ctrl[B_ALUSRC]   = 1'b1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        dec_ctrl[B_REGWRITE] = 1'b1;
        dec_ctrl[B_ALUSRC]   = 1'b1;
        dec_ctrl[B_MEMTOREG] = 1'b1;
        dec_ctrl[B_MEMREAD]  = 1'b1;
      end
      OP_SB, OP_SH, OP_SW: begin
        dec_ctrl[B_ALUSRC]   = 1'b1;
        dec_ctrl[B_MEMWRITE] = 1'b1;
      end
      OP_COP0: begin
        if (rs == RS_MTC0) begin
          dec_ctrl[B_CP0_WRITE] = 1'b1;
        end else if (rs == RS_MFC0) begin
          dec_ctrl[B_REGWRITE] = 1'b1;
          dec_ctrl[B_CP0TOREG] = 1'b1;
        end else if (!(rs == RS_ERET && funct == F_ERET)) begin
          dec_invalid = 1'b1;
        end
      end
      default: dec_invalid = 1'b1;
    endcase
  end

  // Entry payload needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= in_inst;
      pc_mem[wr_ptr]   <= in_pc;
      ctrl_mem[wr_ptr] <= dec_ctrl;
      inv_mem[wr_ptr]  <= dec_invalid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      invalid_cnt <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE_PTR;
      if (pop)  rd_ptr <= rd_ptr + ONE_PTR;
      case ({push, pop})
        2'b10:   count <= count + ONE_COUNT;
        2'b01:   count <= count - ONE_COUNT;
        default: count <= count;
      endcase
      if (push && dec_invalid && (invalid_cnt != '1)) invalid_cnt <= invalid_cnt + ONE_CNT;
    end
  end

  assign out_inst    = out_valid ? inst_mem[rd_ptr] : '0;
  assign out_pc      = out_valid ? pc_mem[rd_ptr]   : '0;
  assign out_ctrl    = out_valid ? ctrl_mem[rd_ptr] : '0;
  assign out_invalid = out_valid ? inv_mem[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: a full-featured instance and a no-mul/div instance
// share one input stream and are compared against a queue-based model.
module tb_decode_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;

  logic        in_ready, out_valid, out_invalid;
  logic [31:0] out_inst, out_pc;
  logic [16:0] out_ctrl;
  logic [2:0]  count;
  logic [15:0] invalid_cnt;

  logic        nm_in_ready, nm_out_valid, nm_out_invalid;
  logic [31:0] nm_out_inst, nm_out_pc;
  logic [16:0] nm_out_ctrl;
  logic [2:0]  nm_count;
  logic [15:0] nm_invalid_cnt;

  logic [63:0] exp_q[$];
  int exp_inv, exp_inv_nm;
  int n_cmp, n_fail;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(DEPTH), .PC_W(32), .HAS_MULDIV(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_ctrl(out_ctrl), .out_invalid(out_invalid),
    .count(count), .invalid_cnt(invalid_cnt));

  decode_queue #(.DEPTH(DEPTH), .PC_W(32), .HAS_MULDIV(0), .CNT_W(CNT_W)) dut_nm (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(nm_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(nm_out_valid), .out_ready(out_ready),
    .out_inst(nm_out_inst), .out_pc(nm_out_pc), .out_ctrl(nm_out_ctrl), .out_invalid(nm_out_invalid),
    .count(nm_count), .invalid_cnt(nm_invalid_cnt));

  // Returns {invalid, ctrl[16:0]} from the instruction-class table.
  function automatic logic [17:0] ref_decode(input logic [31:0] w, input bit md);
    bit rw, alusrc, br, mw, m2r, jmp, hw, jb, jr, c0w, mr, c0r, mfhi, mflo, inv;
    logic [1:0] rd;
    logic [5:0] op, fn;
    logic [4:0] rs, rt;
    {rw, alusrc, br, mw, m2r, jmp, hw, jb, jr, c0w, mr, c0r, mfhi, mflo, inv} = '0;
    rd = 2'b00;
    op = w[31:26]; fn = w[5:0]; rs = w[25:21]; rt = w[20:16];
    if (op == 0) begin
      if (fn inside {32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 4, 6, 7}) begin
        rw = 1; rd = 2'b01;
      end else if (fn inside {16, 18}) begin
        if (md) begin rw = 1; rd = 2'b01; mfhi = (fn == 16); mflo = (fn == 18); end
        else inv = 1;
      end else if (fn inside {17, 19, 24, 25, 26, 27}) begin
        if (md) hw = 1; else inv = 1;
      end else if (fn == 8) jr = 1;
      else if (fn == 9) begin rw = 1; rd = 2'b01; jb = 1; jr = 1; end
      else if (!(fn inside {12, 13})) inv = 1;
    end else if (op == 1) begin
      if (rt inside {0, 1}) br = 1;
      else if (rt inside {16, 17}) begin rw = 1; rd = 2'b10; br = 1; jb = 1; end
      else inv = 1;
    end else if (op == 2) jmp = 1;
    else if (op == 3) begin rw = 1; rd = 2'b10; jmp = 1; jb = 1; end
    else if (op inside {4, 5, 6, 7}) br = 1;
    else if (op inside {[8:15]}) begin rw = 1; alusrc = 1; end
    else if (op inside {32, 33, 35, 36, 37}) begin rw = 1; alusrc = 1; m2r = 1; mr = 1; end
    else if (op inside {40, 41, 43}) begin alusrc = 1; mw = 1; end
    else if (op == 16) begin
      if (rs == 4) c0w = 1;
      else if (rs == 0) begin rw = 1; c0r = 1; end
      else if (!(rs == 16 && fn == 24)) inv = 1;
    end else inv = 1;
    return {inv, rw, rd, alusrc, br, mw, m2r, jmp, hw, jb, jr, c0w, mr, mfhi | mflo, c0r, mfhi, mflo};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic check_all();
    logic [17:0] d, dn;
    logic [63:0] h;
    bit ev;
    ev = (exp_q.size() != 0);
    chk("count", count, exp_q.size());
    chk("nm_count", nm_count, exp_q.size());
    chk("out_valid", out_valid, ev);
    chk("nm_out_valid", nm_out_valid, ev);
    chk("invalid_cnt", invalid_cnt, exp_inv);
    chk("nm_invalid_cnt", nm_invalid_cnt, exp_inv_nm);
    if (ev) begin
      h = exp_q[0];
      d = ref_decode(h[31:0], 1'b1);
      dn = ref_decode(h[31:0], 1'b0);
      chk("out_inst", out_inst, h[31:0]);
      chk("out_pc", out_pc, h[63:32]);
      chk("out_ctrl", out_ctrl, d[16:0]);
      chk("out_invalid", out_invalid, d[17]);
      chk("nm_out_inst", nm_out_inst, h[31:0]);
      chk("nm_out_ctrl", nm_out_ctrl, dn[16:0]);
      chk("nm_out_invalid", nm_out_invalid, dn[17]);
    end else begin
      chk("idle_out", {out_inst, out_pc}, 64'h0);
      chk("idle_ctrl", {out_ctrl, out_invalid, nm_out_ctrl, nm_out_invalid}, 64'h0);
    end
  endtask

  // Advance one clock with the currently driven inputs and update the model.
  task automatic step();
    bit push, pop;
    logic [17:0] d;
    chk("in_ready", in_ready, exp_q.size() < DEPTH);
    chk("nm_in_ready", nm_in_ready, exp_q.size() < DEPTH);
    push = in_valid && (exp_q.size() < DEPTH);
    pop = out_ready && (exp_q.size() != 0);
    @(posedge clk);
    if (flush) exp_q.delete();
    else begin
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        exp_q.push_back({in_pc, in_inst});
        d = ref_decode(in_inst, 1'b1);
        if (d[17] && exp_inv < (1 << CNT_W) - 1) exp_inv++;
        d = ref_decode(in_inst, 1'b0);
        if (d[17] && exp_inv_nm < (1 << CNT_W) - 1) exp_inv_nm++;
      end
    end
    #1;
    check_all();
  endtask

  task automatic drive(input bit v, input logic [31:0] w, input bit rdy, input bit fl);
    in_valid = v; in_inst = w; in_pc = $urandom; out_ready = rdy; flush = fl;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] ops [14];
    ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h09, 6'h0f, 6'h10, 6'h23, 6'h24, 6'h2b, 6'h28, 6'h3f, 6'h11};
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return {ops[$urandom_range(0, 13)], 26'($urandom)};
      2: return {6'h00, 20'($urandom), 6'($urandom_range(0, 43))};
      default: return {6'h10, 5'($urandom_range(0, 4) * 4), 15'($urandom), 6'h18};
    endcase
  endfunction

  initial begin
    logic [15:0] saved_inv;
    n_cmp = 0; n_fail = 0; exp_inv = 0; exp_inv_nm = 0;
    rst = 1'b1;
    drive(0, 32'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Single ADDU appears at the head one cycle after the push.
    drive(1, 32'h00430821, 0, 0);
    step();
    chk("t1_ctrl", out_ctrl, 17'h14000);
    chk("t1_invalid", out_invalid, 1'b0);
    drive(0, 32'h0, 1, 0);
    step();

    // Back-to-back LW, SW, JAL while ID consumes every cycle.
    drive(1, 32'h8C220004, 1, 0); step();
    chk("t2_lw", out_ctrl, 17'h12410);
    drive(1, 32'hAC220008, 1, 0); step();
    chk("t2_sw", out_ctrl, 17'h02800);
    drive(1, 32'h0C000010, 1, 0); step();
    chk("t2_jal", out_ctrl, 17'h18280);
    drive(0, 32'h0, 1, 0); step();

    // Fill to DEPTH, overflow attempt, pop+push while full, then wrap.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h24010000 + i, 0, 0); step();
    end
    chk("t3_count_full", count, 3'd4);
    chk("t3_in_ready", in_ready, 1'b0);
    drive(1, 32'h24010004, 0, 0); step();
    chk("t3_count_hold", count, 3'd4);
    drive(1, 32'h24010005, 1, 0); step();
    chk("t3_popfull_count", count, 3'd3);
    chk("t3_head", out_inst, 32'h24010001);
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'h24020000 + i, i[0], 0); step();
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 32'h0, 1, 0); step();
    end

    // Mul/div group and an undefined opcode on the no-mul/div instance.
    drive(1, 32'h00430018, 0, 0); step();
    chk("t4_mult_inv", nm_out_invalid, 1'b1);
    chk("t4_mult_ctrl", nm_out_ctrl, 17'h0);
    chk("t4_mult_md", out_ctrl, 17'h00100);
    drive(1, 32'hFC000000, 0, 0); step();
    chk("t4_nm_cnt", nm_invalid_cnt, 16'd2);
    chk("t4_md_cnt", invalid_cnt, 16'd1);
    drive(0, 32'h0, 1, 0); step();
    chk("t4_op3f_inv", nm_out_invalid, 1'b1);
    chk("t4_op3f_ctrl", nm_out_ctrl, 17'h0);
    drive(0, 32'h0, 1, 0); step();

    // Flush with three queued and a same-cycle invalid push.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h3C010000 + i, 0, 0); step();
    end
    saved_inv = invalid_cnt;
    drive(1, 32'hFFFFFFFF, 1, 1); step();
    chk("t5_count", count, 3'd0);
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_inv_cnt", invalid_cnt, saved_inv);
    drive(0, 32'h0, 0, 0); step();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 2) != 0,
            $urandom_range(0, 39) == 0);
      step();
    end

    // Asynchronous reset between clock edges.
    drive(1, 32'h00430821, 0, 0); step();
    drive(1, 32'hFFFFFFFF, 0, 0); step();
    drive(0, 32'h0, 0, 0);
    #2 rst = 1'b1;
    #1;
    exp_q.delete(); exp_inv = 0; exp_inv_nm = 0;
    chk("t6_count", count, 3'd0);
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_inv_cnt", invalid_cnt, 16'd0);
    check_all();
    #1 rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
